// File: rtl/pipe_stage_buf_if.sv
// Valid/ready/data handshake bundle used on both sides of the elastic stage buffer.
// The master drives valid/data and the slave drives ready.
interface pipe_stage_buf_if #(
    parameter int unsigned DATA_W = 104
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic in-order pipeline stage buffer with flush, global freeze and
// starvation (bubble) instrumentation.
module pipe_stage_buf #(
    parameter int unsigned DATA_W = 104,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       flush_in,
    pipe_stage_buf_if.slave            in_if,
    pipe_stage_buf_if.master           out_if,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
    output logic [CNT_W-1:0]           bubble_cnt_out
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]    Full = CW'(DEPTH);
    localparam logic [PTR_W-1:0] Last = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;
    logic              empty;
    logic              push;
    logic              pop;

    // in_ready deliberately ignores out_ready: a full buffer never accepts on a pop cycle.
    always_comb begin
        empty        = (count_q == '0);
        in_if.ready  = rdy_in & ~flush_in & ~rst_in & (count_q < Full);
        out_if.valid = rdy_in & ~empty;
        out_if.data  = empty ? '0 : mem_q[rd_ptr_q];
        push         = in_if.valid & rdy_in & ~flush_in & ~rst_in & (count_q < Full);
        pop          = out_if.ready & rdy_in & ~empty;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        bubble_d = bubble_q;
        if (flush_in) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = (wr_ptr_q == Last) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == Last) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            // Downstream ready but nothing to give it; saturate rather than wrap.
            if (rdy_in && out_if.ready && empty && (bubble_q != '1)) begin
                bubble_d = bubble_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            bubble_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            bubble_q <= bubble_d;
        end
    end

    // Payload storage needs no reset; the occupancy count gates what is visible.
    always_ff @(posedge clk_in) begin
        if (push) mem_q[wr_ptr_q] <= in_if.data;
    end

    assign count_out      = count_q;
    assign bubble_cnt_out = bubble_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_pipe_stage_buf;

    localparam int unsigned DW    = 104;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 4;
    localparam int          NV    = 23;

    typedef struct {
        logic       rdy;
        logic       flush;
        logic       vld;
        logic [7:0] data;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_cnt;
        logic [3:0] e_bub;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b1;
    logic          flush = 1'b0;
    logic [1:0]    cnt;
    logic [CW-1:0] bub;
    int            checks = 0;
    int            errors = 0;
    vec_t          tbl [NV];

    pipe_stage_buf_if #(.DATA_W(DW)) in_if ();
    pipe_stage_buf_if #(.DATA_W(DW)) out_if ();

    pipe_stage_buf #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .rdy_in        (rdy),
        .flush_in      (flush),
        .in_if         (in_if),
        .out_if        (out_if),
        .count_out     (cnt),
        .bubble_cnt_out(bub)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic v, input logic [DW-1:0] d,
                         input logic o);
        rdy          = r;
        flush        = f;
        in_if.valid  = v;
        in_if.data   = d;
        out_if.ready = o;
    endtask

    task automatic check_outs(input string tag, input logic e_ir, input logic e_ov,
                              input logic [DW-1:0] e_od, input logic [1:0] e_cnt,
                              input logic [3:0] e_bub);
        chk({tag, ".in_ready"},  DW'(in_if.ready),  DW'(e_ir));
        chk({tag, ".out_valid"}, DW'(out_if.valid), DW'(e_ov));
        chk({tag, ".out_data"},  out_if.data,       e_od);
        chk({tag, ".count"},     DW'(cnt),          DW'(e_cnt));
        chk({tag, ".bubble"},    DW'(bub),          DW'(e_bub));
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        #1;
        check_outs("reset", 1'b0, 1'b0, '0, 2'd0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int i, input logic r, input logic f, input logic v,
                       input logic [7:0] d, input logic o, input logic eir, input logic eov,
                       input logic [7:0] eod, input logic [1:0] ec, input logic [3:0] eb);
        tbl[i] = '{r, f, v, d, o, eir, eov, eod, ec, eb};
    endtask

    initial begin
        logic [DW-1:0] mq [$];
        int            mbub;
        logic [127:0]  rnd;

        //      rdy   flush vld   data   ordy | in_rdy out_v out_d  cnt   bub
        add(0,  1'b1, 1'b0, 1'b1, 8'hA5, 1'b1,  1'b1, 1'b0, 8'h00, 2'd0, 4'd0);
        add(1,  1'b1, 1'b0, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'hA5, 2'd1, 4'd1);
        add(2,  1'b1, 1'b0, 1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 8'h00, 2'd0, 4'd1);
        add(3,  1'b1, 1'b0, 1'b1, 8'h11, 1'b0,  1'b1, 1'b0, 8'h00, 2'd0, 4'd1);
        add(4,  1'b1, 1'b0, 1'b1, 8'h22, 1'b0,  1'b1, 1'b1, 8'h11, 2'd1, 4'd1);
        add(5,  1'b1, 1'b0, 1'b1, 8'h33, 1'b0,  1'b0, 1'b1, 8'h11, 2'd2, 4'd1);
        add(6,  1'b1, 1'b0, 1'b1, 8'h33, 1'b1,  1'b0, 1'b1, 8'h11, 2'd2, 4'd1);
        add(7,  1'b1, 1'b0, 1'b1, 8'h33, 1'b1,  1'b1, 1'b1, 8'h22, 2'd1, 4'd1);
        add(8,  1'b1, 1'b0, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'h33, 2'd1, 4'd1);
        add(9,  1'b1, 1'b0, 1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 8'h00, 2'd0, 4'd1);
        add(10, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0,  1'b1, 1'b0, 8'h00, 2'd0, 4'd1);
        add(11, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0,  1'b1, 1'b1, 8'h44, 2'd1, 4'd1);
        add(12, 1'b1, 1'b1, 1'b1, 8'h66, 1'b1,  1'b0, 1'b1, 8'h44, 2'd2, 4'd1);
        add(13, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0,  1'b1, 1'b0, 8'h00, 2'd0, 4'd1);
        add(14, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1,  1'b1, 1'b1, 8'h77, 2'd1, 4'd1);
        add(15, 1'b0, 1'b0, 1'b1, 8'h99, 1'b1,  1'b0, 1'b0, 8'h5A, 2'd1, 4'd1);
        add(16, 1'b0, 1'b0, 1'b1, 8'h99, 1'b1,  1'b0, 1'b0, 8'h5A, 2'd1, 4'd1);
        add(17, 1'b0, 1'b0, 1'b1, 8'h99, 1'b1,  1'b0, 1'b0, 8'h5A, 2'd1, 4'd1);
        add(18, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1,  1'b1, 1'b1, 8'h5A, 2'd1, 4'd1);
        add(19, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 8'h00, 2'd0, 4'd1);
        add(20, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1,  1'b0, 1'b0, 8'h00, 2'd0, 4'd1);
        add(21, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1,  1'b1, 1'b0, 8'h00, 2'd0, 4'd1);
        add(22, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 8'h00, 2'd0, 4'd2);

        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        do_reset();

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rdy, tbl[i].flush, tbl[i].vld, DW'(tbl[i].data), tbl[i].ordy);
            #2;
            check_outs($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_ov, DW'(tbl[i].e_od),
                       tbl[i].e_cnt, tbl[i].e_bub);
            @(posedge clk);
            #1;
        end

        // Bubble counter saturation on an idle, always-ready downstream.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
            #2;
            chk($sformatf("sat%0d.bubble", i), DW'(bub), DW'((i > 15) ? 15 : i));
            @(posedge clk);
            #1;
        end
        chk("sat_final.bubble", DW'(bub), DW'(15));

        // Async reset between edges with two entries held.
        drive(1'b1, 1'b0, 1'b1, DW'(8'hC1), 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b1, DW'(8'hC2), 1'b0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        #2;
        check_outs("pre_rst", 1'b0, 1'b1, DW'(8'hC1), 2'd2, 4'd15);
        rst = 1'b1;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, '0, 2'd0, 4'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic against a queue model.
        mq.delete();
        mbub = 0;
        for (int n = 0; n < 2000; n++) begin
            logic r, f, v, o, eir, eov, was_empty;
            logic [DW-1:0] d, eod;
            r   = ($urandom_range(0, 9) != 0);
            f   = ($urandom_range(0, 19) == 0);
            v   = ($urandom_range(0, 2) != 0);
            o   = ($urandom_range(0, 2) != 0);
            rnd = {$urandom, $urandom, $urandom, $urandom};
            d   = rnd[DW-1:0];
            drive(r, f, v, d, o);
            #2;
            was_empty = (mq.size() == 0);
            eir = r && !f && (mq.size() < DEPTH);
            eov = r && !was_empty;
            eod = was_empty ? '0 : mq[0];
            check_outs($sformatf("rnd%0d", n), eir, eov, eod, 2'(mq.size()), 4'(mbub));
            if (f) begin
                mq.delete();
            end else if (r) begin
                if (eov && o) void'(mq.pop_front());
                if (eir && v) mq.push_back(d);
                if (o && was_empty && mbub < 15) mbub++;
            end
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised, elastic successor to the fixed EX-to-MEM stage register. It carries an opaque stage payload through a DEPTH-entry in-order buffer using a valid/ready handshake in place of the global stall vector. It adds a synchronous flush for branch redirect, global rdy_in freezing, and occupancy and bubble instrumentation. It sits between any two pipeline stages; the EX/MEM instance packs rd addr, rd data, rd write enable, branch taken, branch target, mem addr and mem read into in_data.

Parameters:
DATA_W, 104, payload width in bits (EX/MEM bundle: 5+32+1+1+32+32+1).
DEPTH, 2, buffer entries; power of two, >= 1.
CNT_W, 16, width of the saturating bubble counter.

Ports:
clk_in  input  1  clock; all state changes on posedge.
rst_in  input  1  reset, asynchronous, active-high.
rdy_in  input  1  global ready; 0 freezes the block.
flush_in  input  1  synchronous flush; discards all contents.
in_valid  input  1  upstream offers in_data.
in_ready  output  1  block can accept this cycle.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  head entry valid.
out_ready  input  1  downstream accepts head.
out_data  output  DATA_W  head payload.
count_out  output  $clog2(DEPTH+1)  current occupancy.
bubble_cnt_out  output  CNT_W  cycles downstream was ready but starved.

Behaviour:
- Reset (async, rst_in=1): count=0, read/write pointers=0, bubble_cnt_out=0, out_valid=0, out_data=0, in_ready=0 while rst_in is high. Storage contents are don't-care. Reset mid-transfer drops all entries immediately without waiting for a clock edge.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = rdy_in & (count < DEPTH) & ~flush_in. There is no combinational path from out_ready to in_ready, so a full buffer does not accept in the same cycle it pops.
- out_valid = rdy_in & (count != 0). out_data = mem[rd_ptr] when count != 0, else all zeros. There is no bypass: data pushed at edge N is first visible after edge N, so minimum latency is 1 cycle.
- Priority at each posedge, with rst_in low:
  - flush_in=1: count, rd_ptr and wr_ptr go to 0. Any concurrent push or pop is discarded. The bubble counter is unchanged.
  - else rdy_in=0: no state changes at all (full freeze); the handshakes are masked to 0.
  - else push only: write at wr_ptr, wr_ptr+1, count+1.
  - else pop only: rd_ptr+1, count-1.
  - else push and pop together: both pointers advance and count is unchanged. This is legal only when 0 < count < DEPTH.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. For DEPTH=1 the pointers are constant 0 and count is 0 or 1.
- count_out reflects the registered count. It is never greater than DEPTH and never underflows.
- Bubble counter: increments when rdy_in=1, flush_in=0, out_ready=1 and count==0. It saturates at 2^CNT_W-1 and does not wrap.
- Ordering: strict FIFO order is preserved. Every pushed payload is popped exactly once unless it is discarded by flush or reset.

Test Plan:
- Single transfer, DEPTH=2: push 0xA5 at edge 1 with out_ready=1 -> out_valid=1 and out_data=0xA5 after edge 1; popped at edge 2; count_out goes 0,1,0.
- Fill and back-pressure: out_ready=0, push 0x11, 0x22, 0x33 on consecutive cycles -> in_ready=0 after second push, 0x33 held upstream, count_out=2. Then out_ready=1 -> outputs 0x11, 0x22, 0x33 in order; pointers wrap, no loss.
- Flush with concurrent traffic: count=2, flush_in=1 with in_valid=1 and out_ready=1 -> after edge count_out=0, out_valid=0, nothing accepted; the next push of 0x77 appears as out_data=0x77.
- rdy_in freeze: count=1 holding 0x5A, rdy_in=0 for 3 cycles with in_valid=1 and out_ready=1 -> in_ready=0, out_valid=0, count_out=1, bubble counter unchanged. rdy_in back to 1 -> 0x5A delivered.
- Bubble saturation, CNT_W=4: empty buffer, out_ready=1 for 20 cycles -> bubble_cnt_out counts 1..15 and holds at 15.
- Async reset mid-operation: count=2; assert rst_in between edges -> out_valid=0, count_out=0 and bubble_cnt_out=0 immediately, before the next posedge.
